// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg
//   Shared types and address decode for the AXI4-Lite register bank.
//   resp_t      : AXI response codes
//   wr_state_t  : write-channel FSM states
//   dec_t       : decode result {hit, idx}
//   addr_decode : byte address -> register index, with a range check
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] idx;
    } dec_t;

    // lsb = log2(bytes per register). Sub-word address bits fall out in the shift.
    // The addr >= base term catches the wrap of addr - base below the window.
    function automatic dec_t addr_decode(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] num,
                                         input int unsigned lsb);
        dec_t        d;
        logic [63:0] word;
        word  = (addr - base) >> lsb;
        d.hit = (addr >= base) && (word < num);
        d.idx = word[31:0];
        return d;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if
//   AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master modport: drives valids, addresses, write data, bready/rready.
//   slave modport : drives readies, bvalid/bresp, rvalid/rdata/rresp.
//   wstrb exists only when AXI4_LITE_STRB_EN is defined.
interface axi4_lite_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
`ifdef AXI4_LITE_STRB_EN
    logic [DATA_WIDTH/8-1:0] wstrb;
`endif
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
`ifdef AXI4_LITE_STRB_EN
        output wstrb,
`endif
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
`ifdef AXI4_LITE_STRB_EN
        input  wstrb,
`endif
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_wr_ctrl.sv
// axi4_lite_wr_ctrl
//   Write-channel FSM with AW/W holding registers. AW and W are accepted
//   independently; the edge that completes the pair moves to RESP and raises
//   commit in the same cycle, so the register file updates on that edge.
//   Ports: clk/rst, AW (awvalid/awready/awaddr), W (wvalid/wready/wdata/wstrb),
//          B (bvalid/bready/bresp), commit strobe + commit_hit/idx/data/strb.
module axi4_lite_wr_ctrl
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output resp_t                   bresp,
    output logic                    commit,
    output logic                    commit_hit,
    output logic [IDX_W-1:0]        commit_idx,
    output logic [DATA_WIDTH-1:0]   commit_data,
    output logic [DATA_WIDTH/8-1:0] commit_strb
);

    wr_state_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
    resp_t                   bresp_q, bresp_d;
    logic                    aw_hs, w_hs;
    dec_t                    dec;
    logic [31-IDX_W:0]       unused_idx_hi;

    // Readies depend only on state (and are held low in reset).
    assign awready = !rst && (state_q == WR_IDLE || state_q == WR_HAVE_W);
    assign wready  = !rst && (state_q == WR_IDLE || state_q == WR_HAVE_AW);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign bvalid  = (state_q == WR_RESP);
    assign bresp   = bresp_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        if (aw_hs) addr_d = awaddr;
        if (w_hs) begin
            data_d = wdata;
            strb_d = wstrb;
        end
        unique case (state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) state_d = WR_RESP;
                else if (aw_hs)    state_d = WR_HAVE_AW;
                else if (w_hs)     state_d = WR_HAVE_W;
            end
            WR_HAVE_AW: if (w_hs)   state_d = WR_RESP;
            WR_HAVE_W:  if (aw_hs)  state_d = WR_RESP;
            WR_RESP:    if (bready) state_d = WR_IDLE;
            default:                state_d = WR_IDLE;
        endcase
    end

    // addr_d/data_d already carry whichever half arrived this cycle.
    assign dec           = addr_decode(64'(addr_d), BASE_ADDR, 64'(NUM_REGS),
                                       $clog2(DATA_WIDTH / 8));
    assign commit        = (state_q != WR_RESP) && (state_d == WR_RESP);
    assign commit_hit    = dec.hit;
    assign commit_idx    = dec.idx[IDX_W-1:0];
    assign unused_idx_hi = dec.idx[31:IDX_W];
    assign commit_data   = data_d;
    assign commit_strb   = strb_d;
    assign bresp_d       = commit ? (dec.hit ? OKAY : SLVERR) : bresp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WR_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            bresp_q <= bresp_d;
        end
    end

endmodule

// File: rtl/axi4_lite_reg_bank.sv
// axi4_lite_reg_bank
//   AXI4-Lite CSR endpoint: NUM_REGS registers of DATA_WIDTH bits at BASE_ADDR.
//   Decode misses answer SLVERR (reads return 0).
//   Ports: aclk, areset (sync, active-high), s_axi (axi4_lite_if.slave),
//          reg_q (flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]),
//          reg_wr_pulse (one cycle per committed register write).
//   Build option AXI4_LITE_STRB_EN: honour wstrb byte lanes; otherwise every
//   write replaces the full word.
module axi4_lite_reg_bank
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter logic [63:0] BASE_ADDR  = 64'h0
) (
    input  logic                           aclk,
    input  logic                           areset,
    axi4_lite_if.slave                     s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [STRB_W-1:0]     wstrb_in;
    logic                  wr_commit, wr_hit;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    resp_t                 wr_bresp;

`ifdef AXI4_LITE_STRB_EN
    assign wstrb_in = s_axi.wstrb;
`else
    assign wstrb_in = '1;
`endif

    axi4_lite_wr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_wr_ctrl (
        .clk         (aclk),
        .rst         (areset),
        .awvalid     (s_axi.awvalid),
        .awready     (s_axi.awready),
        .awaddr      (s_axi.awaddr),
        .wvalid      (s_axi.wvalid),
        .wready      (s_axi.wready),
        .wdata       (s_axi.wdata),
        .wstrb       (wstrb_in),
        .bvalid      (s_axi.bvalid),
        .bready      (s_axi.bready),
        .bresp       (wr_bresp),
        .commit      (wr_commit),
        .commit_hit  (wr_hit),
        .commit_idx  (wr_idx),
        .commit_data (wr_data),
        .commit_strb (wr_strb)
    );

    assign s_axi.bresp = wr_bresp;

    // ---------------- register file ----------------
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 pulse_q, pulse_d;

    // A hit with wstrb=0 still pulses: the write was accepted, just changed nothing.
    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        if (wr_commit && wr_hit) begin
            pulse_d[wr_idx] = 1'b1;
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wr_strb[b]) regs_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    assign reg_q        = regs_q;
    assign reg_wr_pulse = pulse_q;

    // ---------------- read path ----------------
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    resp_t                 rresp_q, rresp_d;
    dec_t                  rd_dec;
    logic [31-IDX_W:0]     unused_rd_idx_hi;

    assign rd_dec           = addr_decode(64'(s_axi.araddr), BASE_ADDR, 64'(NUM_REGS),
                                          $clog2(DATA_WIDTH / 8));
    assign unused_rd_idx_hi = rd_dec.idx[31:IDX_W];
    assign s_axi.arready    = !areset && !rvalid_q;
    assign s_axi.rvalid     = rvalid_q;
    assign s_axi.rdata      = rdata_q;
    assign s_axi.rresp      = rresp_q;

    // Reads sample regs_q, so a write committing on the same edge is not yet visible.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && s_axi.rready) rvalid_d = 1'b0;
        if (s_axi.arvalid && s_axi.arready) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_dec.hit ? OKAY : SLVERR;
            rdata_d  = rd_dec.hit ? regs_q[rd_dec.idx[IDX_W-1:0]] : '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            regs_q   <= '0;
            pulse_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
        end else begin
            regs_q   <= regs_d;
            pulse_q  <= pulse_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

endmodule
